fetch_stage: RTL and testbench

//   F stage of the 5-stage MIPS pipeline: owns the PC register and the F/D pipeline register.

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_npc.sv | 39 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and types for the F stage.
//   npc_op_e   : D-stage next-PC select codes (seq / br / j / jr)
//   fd_t       : F/D pipeline register contents (instruction + its address)
//   DEF_*      : default reset PC and exception vector
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fd_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  // Size of the legal instruction window starting at RESET_PC.
  localparam logic [31:0] IM_SPAN      = 32'h0000_1000;

endpackage

// File: rtl/fetch_stage_npc.sv
// fetch_stage_npc: pure combinational next-PC mux.
//   pc_f    in  32  current fetch address
//   pc_d    in  32  address of the instruction in D (the branch/jump)
//   npcop   in   2  next-PC select
//   branch  in   1  comparator result, only used for NPC_BR
//   imm26   in  26  [15:0] branch offset, [25:0] jump index
//   rs      in  32  jr/jalr target
//   npc     out 32  next fetch address (modular, carries dropped)
module fetch_stage_npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  npc_op_e     npcop,
  input  logic        branch,
  input  logic [25:0] imm26,
  input  logic [31:0] rs,
  output logic [31:0] npc
);

  logic [31:0] seq, br_tgt, j_tgt;

  assign seq    = pc_f + 32'd4;
  // Branch target is relative to the delay slot (PC_D + 4).
  assign br_tgt = pc_d + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign j_tgt  = {pc_d[31:28], imm26, 2'b00};

  always_comb begin
    npc = seq;
    unique case (npcop)
      NPC_SEQ: npc = seq;
      NPC_BR:  npc = branch ? br_tgt : seq;
      NPC_J:   npc = j_tgt;
      NPC_JR:  npc = rs;
      default: npc = seq;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: F stage of the 5-stage MIPS pipeline. Owns PC_F and the F/D
// register; the slot after a branch is never squashed (one delay slot).
// Optional macro FETCH_EXC_EN adds exception entry, eret and the fetch
// address-error check.
//   clk, reset  clock / async active-high reset
//   Stall       hold PC_F and F/D
//   NPCOp       next-PC select from D; Branch qualifies NPC_BR
//   Imm26_D     offset/index field of IR_D; RegRs_D jr target
//   Instr_F     IM read data at PC_F
//   PC_F        fetch address;  IR_D/PC_D  F/D register;  PC8_D  link value
//   [FETCH_EXC_EN] ExcFlush, Eret, EPC in; AdEL_D out
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef FETCH_EXC_EN
  ,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
`endif
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  NPCOp,
  input  logic        Branch,
  input  logic [25:0] Imm26_D,
  input  logic [31:0] RegRs_D,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D
`ifdef FETCH_EXC_EN
  ,
  input  logic        ExcFlush,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic        AdEL_D
`endif
);

  logic [31:0] pc_f, npc;
  fd_t         fd;

  fetch_stage_npc u_npc (
    .pc_f   (pc_f),
    .pc_d   (fd.pc),
    .npcop  (npc_op_e'(NPCOp)),
    .branch (Branch),
    .imm26  (Imm26_D),
    .rs     (RegRs_D),
    .npc    (npc)
  );

`ifdef FETCH_EXC_EN
  logic adel_f, adel_d;

  // Fetch outside the word-aligned IM window is flagged and turned into a nop.
  assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < RESET_PC) ||
                  (pc_f >= RESET_PC + IM_SPAN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f   <= RESET_PC;
      fd     <= '{ir: '0, pc: RESET_PC};
      adel_d <= 1'b0;
    end else if (ExcFlush) begin
      pc_f   <= EXC_VEC;
      fd     <= '{ir: '0, pc: EXC_VEC};
      adel_d <= 1'b0;
    end else if (Eret) begin
      // Bubble enters D; the return target is fetched next.
      pc_f   <= EPC;
      fd     <= '{ir: '0, pc: EPC};
      adel_d <= 1'b0;
    end else if (!Stall) begin
      pc_f   <= npc;
      fd     <= '{ir: adel_f ? 32'd0 : Instr_F, pc: pc_f};
      adel_d <= adel_f;
    end
  end

  assign AdEL_D = adel_d;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
      fd   <= '{ir: '0, pc: RESET_PC};
    end else if (!Stall) begin
      pc_f <= npc;
      fd   <= '{ir: Instr_F, pc: pc_f};
    end
  end
`endif

  // A stall holds D, so any redirect is simply recomputed from the held D
  // state once the stall releases.
  assign PC_F  = pc_f;
  assign IR_D  = fd.ir;
  assign PC_D  = fd.pc;
  assign PC8_D = fd.pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed test for fetch_stage. The IM is
// modelled as Instr_F = ~PC_F so every IR_D value is predictable from PC_D.
// Build with FETCH_EXC_EN defined to also exercise the exception paths.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Stall, Branch;
  logic [1:0]  NPCOp;
  logic [25:0] Imm26_D;
  logic [31:0] RegRs_D, Instr_F, PC_F, IR_D, PC_D, PC8_D;
`ifdef FETCH_EXC_EN
  logic        ExcFlush, Eret, AdEL_D;
  logic [31:0] EPC;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;
  assign Instr_F = ~PC_F;

  fetch_stage dut (
    .clk     (clk),
    .reset   (reset),
    .Stall   (Stall),
    .NPCOp   (NPCOp),
    .Branch  (Branch),
    .Imm26_D (Imm26_D),
    .RegRs_D (RegRs_D),
    .Instr_F (Instr_F),
    .PC_F    (PC_F),
    .IR_D    (IR_D),
    .PC_D    (PC_D),
    .PC8_D   (PC8_D)
`ifdef FETCH_EXC_EN
    ,
    .ExcFlush(ExcFlush),
    .Eret    (Eret),
    .EPC     (EPC),
    .AdEL_D  (AdEL_D)
`endif
  );

  typedef struct {
    logic        stall;
    logic [1:0]  op;
    logic        br;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] exp_pcf;
    logic [31:0] exp_pcd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [1:0] op, input logic br,
                     input logic [25:0] imm, input logic [31:0] rs,
                     input logic [31:0] pcf, input logic [31:0] pcd);
    vec_t v;
    v.stall = st; v.op = op; v.br = br; v.imm = imm; v.rs = rs;
    v.exp_pcf = pcf; v.exp_pcd = pcd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic exp_adel(input logic [31:0] pc);
`ifdef FETCH_EXC_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc >= 32'h4000);
`else
    return 1'b0;
`endif
  endfunction

  // Check the full F/D state after a normal load of pcd into D.
  task automatic chk_state(input string tag, input logic [31:0] pcf, input logic [31:0] pcd);
    logic a;
    a = exp_adel(pcd);
    chk({tag, " PC_F"},  PC_F,  pcf);
    chk({tag, " PC_D"},  PC_D,  pcd);
    chk({tag, " IR_D"},  IR_D,  a ? 32'd0 : ~pcd);
    chk({tag, " PC8_D"}, PC8_D, pcd + 32'd8);
`ifdef FETCH_EXC_EN
    chk({tag, " AdEL_D"}, {31'd0, AdEL_D}, {31'd0, a});
`endif
  endtask

  task automatic drive(input logic st, input logic [1:0] op, input logic br,
                       input logic [25:0] imm, input logic [31:0] rs);
    Stall = st; NPCOp = op; Branch = br; Imm26_D = imm; RegRs_D = rs;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, NPC_SEQ, 1'b0, 26'd0, 32'd0);
`ifdef FETCH_EXC_EN
    ExcFlush = 1'b0; Eret = 1'b0; EPC = 32'd0;
`endif

    // Sequential fetch, then taken branch with its delay slot.
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_3004, 32'h0000_3000);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_3008, 32'h0000_3004);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_300C, 32'h0000_3008);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_3010, 32'h0000_300C);
    add(0, NPC_BR,  1, 26'h000FFFD, 32'd0,       32'h0000_3004, 32'h0000_3010);
    // Back to PC_D=300C, same branch not taken: no bubble.
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_3008, 32'h0000_3004);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_300C, 32'h0000_3008);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_3010, 32'h0000_300C);
    add(0, NPC_BR,  0, 26'h000FFFD, 32'd0,       32'h0000_3014, 32'h0000_3010);
    // jr held by a two-cycle stall.
    add(1, NPC_JR,  0, 26'd0,      32'h0000_3040, 32'h0000_3014, 32'h0000_3010);
    add(1, NPC_JR,  0, 26'd0,      32'h0000_3040, 32'h0000_3014, 32'h0000_3010);
    add(0, NPC_JR,  0, 26'd0,      32'h0000_3040, 32'h0000_3040, 32'h0000_3014);
    // Forward taken branch: PC_D=3014 -> 3018 + 8 = 3020.
    add(0, NPC_BR,  1, 26'h0000002, 32'd0,       32'h0000_3020, 32'h0000_3040);
    // j keeps PC_D[31:28].
    add(0, NPC_JR,  0, 26'd0,      32'h3000_3000, 32'h3000_3000, 32'h0000_3020);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h3000_3004, 32'h3000_3000);
    add(0, NPC_J,   0, 26'h0000C04, 32'd0,       32'h3000_3010, 32'h3000_3004);
    // Wrap at the top of the address space.
    add(0, NPC_JR,  0, 26'd0,      32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3000_3010);
    add(0, NPC_SEQ, 0, 26'd0,      32'd0,        32'h0000_0000, 32'hFFFF_FFFC);

    #12;
    chk("reset PC_F",  PC_F,  32'h0000_3000);
    chk("reset PC_D",  PC_D,  32'h0000_3000);
    chk("reset IR_D",  IR_D,  32'd0);
    chk("reset PC8_D", PC8_D, 32'h0000_3008);
    @(posedge clk); #1;
    chk("reset held PC_F", PC_F, 32'h0000_3000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].op, vecs[i].br, vecs[i].imm, vecs[i].rs);
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d", i), vecs[i].exp_pcf, vecs[i].exp_pcd);
    end

    // Async reset in the middle of a stalled jr.
    drive(1'b1, NPC_JR, 1'b0, 26'd0, 32'h0000_3100);
    @(posedge clk); #1;
    chk("stall hold PC_F", PC_F, 32'h0000_0000);
    #2 reset = 1'b1;
    #1;
    chk("async rst PC_F", PC_F, 32'h0000_3000);
    chk("async rst PC_D", PC_D, 32'h0000_3000);
    chk("async rst IR_D", IR_D, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, NPC_SEQ, 1'b0, 26'd0, 32'd0);
    @(posedge clk); #1;
    chk_state("post rst", 32'h0000_3004, 32'h0000_3000);

`ifdef FETCH_EXC_EN
    // Exception entry wins over Stall.
    drive(1'b1, NPC_JR, 1'b0, 26'd0, 32'h0000_3200);
    ExcFlush = 1'b1;
    @(posedge clk); #1;
    ExcFlush = 1'b0;
    chk("exc PC_F", PC_F, 32'h0000_4180);
    chk("exc PC_D", PC_D, 32'h0000_4180);
    chk("exc IR_D", IR_D, 32'd0);
    chk("exc AdEL_D", {31'd0, AdEL_D}, 32'd0);
    // Eret to EPC, also overriding Stall.
    Eret = 1'b1; EPC = 32'h0000_3008;
    @(posedge clk); #1;
    Eret = 1'b0;
    chk("eret PC_F", PC_F, 32'h0000_3008);
    chk("eret PC_D", PC_D, 32'h0000_3008);
    chk("eret IR_D", IR_D, 32'd0);
    drive(1'b0, NPC_SEQ, 1'b0, 26'd0, 32'd0);
    @(posedge clk); #1;
    chk_state("after eret", 32'h0000_300C, 32'h0000_3008);
    // Misaligned jr target flagged once it reaches D.
    drive(1'b0, NPC_JR, 1'b0, 26'd0, 32'h0000_3002);
    @(posedge clk); #1;
    chk("jr mis PC_F", PC_F, 32'h0000_3002);
    drive(1'b0, NPC_SEQ, 1'b0, 26'd0, 32'd0);
    @(posedge clk); #1;
    chk("adel flag", {31'd0, AdEL_D}, 32'd1);
    chk("adel IR_D", IR_D, 32'd0);
    chk("adel PC_D", PC_D, 32'h0000_3002);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
